// File: rtl/drbg_pkg.sv
// drbg_pkg: shared types and constants for the xoshiro256** DRBG stage.
// FSM state encoding, xoshiro rotation/multiplier constants and the
// default reseed interval / retry limit used by drbg_xoshiro.
package drbg_pkg;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PRIME = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } drbg_state_e;

  // xoshiro256** constants
  localparam int unsigned ROT_SCRAMBLE = 7;
  localparam int unsigned SHL_STEP     = 17;
  localparam int unsigned ROT_STEP     = 45;
  localparam logic [63:0] MUL_PRE      = 64'd5;
  localparam logic [63:0] MUL_POST     = 64'd9;

  localparam int unsigned DEFAULT_RESEED_INTERVAL = 1024;
  localparam int unsigned DEFAULT_MAX_SEED_RETRY  = 3;

  // 64-bit rotate left by a non-zero constant amount
  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned k);
    return (x << k) | (x >> (64 - k));
  endfunction

endpackage

// File: rtl/drbg_xoshiro_step.sv
// xoshiro256ss_step: purely combinational xoshiro256** update.
// Produces the next state (s0..s3) and the scrambled output word
// derived from the current s1.
module xoshiro256ss_step
  import drbg_pkg::*;
(
  input  logic [63:0] s0,
  input  logic [63:0] s1,
  input  logic [63:0] s2,
  input  logic [63:0] s3,
  output logic [63:0] s0_next,
  output logic [63:0] s1_next,
  output logic [63:0] s2_next,
  output logic [63:0] s3_next,
  output logic [63:0] word
);

  logic [63:0] t_s;
  logic [63:0] a2_s;
  logic [63:0] a3_s;
  logic [63:0] mul_pre_s;
  logic [63:0] rot_s;

  // State transition, each line consuming the values updated by the previous one
  always_comb begin
    t_s     = s1 << SHL_STEP;
    a2_s    = s2 ^ s0;
    a3_s    = s3 ^ s1;
    s1_next = s1 ^ a2_s;
    s0_next = s0 ^ a3_s;
    s2_next = a2_s ^ t_s;
    s3_next = rotl64(a3_s, ROT_STEP);
  end

  // Output scrambler: rotl(s1*5, 7)*9, products truncated to 64 bits
  always_comb begin
    mul_pre_s = s1 * MUL_PRE;
    rot_s     = rotl64(mul_pre_s, ROT_SCRAMBLE);
    word      = rot_s * MUL_POST;
  end

endmodule

// File: rtl/drbg_xoshiro.sv
// drbg_xoshiro: seeded xoshiro256** DRBG with valid/ready output stream.
// Requests a 256-bit seed, rejects all-zero seeds (retrying up to
// MAX_SEED_RETRY times before a sticky fault), primes the generator and
// streams 64-bit words, reseeding every RESEED_INTERVAL words or on request.
// Optional feature macro: DRBG_SEED_REPEAT_CHECK_EN -- also rejects a seed
// identical to the previously accepted one.
module drbg_xoshiro
  import drbg_pkg::*;
#(
  parameter int unsigned RESEED_INTERVAL = DEFAULT_RESEED_INTERVAL,
  parameter int unsigned MAX_SEED_RETRY  = DEFAULT_MAX_SEED_RETRY
) (
  input  logic         clk,
  input  logic         rst,
  output logic         seed_req,
  input  logic [255:0] seed_in,
  input  logic         seed_ready,
  input  logic         reseed_req,
  output logic         rnd_valid,
  input  logic         rnd_ready,
  output logic [63:0]  rnd_data,
  output logic         fault
);

  localparam logic [20:0] INTERVAL_C    = 21'(RESEED_INTERVAL);
  localparam logic [3:0]  RETRY_LIMIT_C = 4'(MAX_SEED_RETRY);

  drbg_state_e state_r;
  drbg_state_e state_next_s;

  logic [63:0] s0_r, s1_r, s2_r, s3_r;
  logic [63:0] s0_next_s, s1_next_s, s2_next_s, s3_next_s;
  logic [63:0] word_s;
  logic [63:0] out_r;
  logic [20:0] cnt_r;
  logic [20:0] cnt_inc_s;
  logic [3:0]  retry_r;
  logic [3:0]  retry_inc_s;
  logic        seed_bad_s;
  logic        handshake_s;

  xoshiro256ss_step u_step (
    .s0      (s0_r),
    .s1      (s1_r),
    .s2      (s2_r),
    .s3      (s3_r),
    .s0_next (s0_next_s),
    .s1_next (s1_next_s),
    .s2_next (s2_next_s),
    .s3_next (s3_next_s),
    .word    (word_s)
  );

`ifdef DRBG_SEED_REPEAT_CHECK_EN
  logic [255:0] prev_seed_r;

  // Remember the last accepted seed so an identical repeat can be rejected
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_seed_r <= 256'd0;
    end else if ((state_r == ST_WAIT) && seed_ready && !seed_bad_s) begin
      prev_seed_r <= seed_in;
    end else begin
      prev_seed_r <= prev_seed_r;
    end
  end

  // Zero seed (absorbing state) or a repeat of the previous seed is rejected
  always_comb begin
    seed_bad_s = (seed_in == 256'd0) || (seed_in == prev_seed_r);
  end
`else
  // Zero seed is rejected: the all-zero xoshiro state never leaves zero
  always_comb begin
    seed_bad_s = (seed_in == 256'd0);
  end
`endif

  // Handshake and counter increments shared by FSM and datapath
  always_comb begin
    handshake_s = (state_r == ST_RUN) && rnd_ready;
    cnt_inc_s   = cnt_r + 21'd1;
    retry_inc_s = retry_r + 4'd1;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_REQ: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (seed_ready) begin
          if (seed_bad_s) begin
            if (retry_inc_s >= RETRY_LIMIT_C) begin
              state_next_s = ST_FAULT;
            end else begin
              state_next_s = ST_REQ;
            end
          end else begin
            state_next_s = ST_PRIME;
          end
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_PRIME: begin
        state_next_s = ST_RUN;
      end
      ST_RUN: begin
        if (reseed_req || (handshake_s && (cnt_inc_s == INTERVAL_C))) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        state_next_s = ST_FAULT;
      end
      default: begin
        state_next_s = ST_FAULT;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Generator state, output word, word counter and retry counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_r    <= 64'd0;
      s1_r    <= 64'd0;
      s2_r    <= 64'd0;
      s3_r    <= 64'd0;
      out_r   <= 64'd0;
      cnt_r   <= 21'd0;
      retry_r <= 4'd0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (seed_ready && seed_bad_s) begin
            retry_r <= retry_inc_s;
          end else if (seed_ready) begin
            s0_r    <= seed_in[63:0];
            s1_r    <= seed_in[127:64];
            s2_r    <= seed_in[191:128];
            s3_r    <= seed_in[255:192];
            retry_r <= 4'd0;
          end else begin
            retry_r <= retry_r;
          end
        end
        ST_PRIME: begin
          out_r <= word_s;
          s0_r  <= s0_next_s;
          s1_r  <= s1_next_s;
          s2_r  <= s2_next_s;
          s3_r  <= s3_next_s;
          cnt_r <= 21'd0;
        end
        ST_RUN: begin
          // out_r only moves on a handshake, so rnd_data is stable while stalled
          if (handshake_s) begin
            out_r <= word_s;
            s0_r  <= s0_next_s;
            s1_r  <= s1_next_s;
            s2_r  <= s2_next_s;
            s3_r  <= s3_next_s;
            cnt_r <= cnt_inc_s;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // seed_req is gated by rst so it reads 0 while reset is held even though
  // the FSM already sits in REQ, and rises as soon as reset is released
  assign seed_req  = (state_r == ST_REQ) && rst;
  assign rnd_valid = (state_r == ST_RUN);
  assign fault     = (state_r == ST_FAULT);
  assign rnd_data  = out_r;

endmodule

// File: doc/drbg_xoshiro.md
# drbg_xoshiro

Deterministic random bit generator stage sitting directly downstream of the TRNG seed system and upstream of the masked Gaussian sampler. It requests a 256-bit seed, checks and loads it into a xoshiro256** state, and streams 64-bit pseudo-random words over a valid/ready handshake. After a programmable number of output words, or on demand, it reseeds itself through the same seed request path.

## Interface
Parameters:
- RESEED_INTERVAL, 1024: words delivered per seed before an automatic reseed (legal range 1..2^20).
- MAX_SEED_RETRY, 3: consecutive rejected seeds before entering FAULT (legal range 1..15).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- seed_req  out  1  one-cycle pulse, wired to start_seed_collection of the seed system.
- seed_in  in  256  seed word; s0=[63:0], s1=[127:64], s2=[191:128], s3=[255:192].
- seed_ready  in  1  seed_in valid; sampled only in WAIT.
- reseed_req  in  1  force a reseed; honoured only in RUN.
- rnd_valid  out  1  rnd_data holds a valid word.
- rnd_ready  in  1  consumer accepts rnd_data.
- rnd_data  out  64  pseudo-random word.
- fault  out  1  sticky seed failure; cleared only by rst.

## Operation
- FSM states: REQ, WAIT, PRIME, RUN, FAULT. Reset state: REQ.
- REQ: seed_req=1 for exactly this cycle; next state WAIT.
- WAIT: hold until seed_ready=1. Seed rejected if seed_in == 0 (xoshiro zero state is absorbing). On reject: retry counter +1; if it reaches MAX_SEED_RETRY go FAULT, else REQ. On accept: state regs <= seed_in, retry counter <= 0, go PRIME.
- PRIME: out_reg <= scramble(s1); state <= step(state); word counter <= 0; go RUN.
- RUN: rnd_valid=1, rnd_data=out_reg. On handshake (rnd_valid & rnd_ready): out_reg <= scramble(s1), state <= step(state), counter +1.
- scramble(s1) = rotl(s1*5, 7)*9, all products truncated to 64 bits.
- step: t=s1<<17; s2^=s0; s3^=s1; s1^=s2; s0^=s3; s2^=t; s3=rotl(s3,45) (sequential semantics, each line uses updated values).
- Leave RUN for REQ when a handshake brings counter to RESEED_INTERVAL, or when reseed_req=1 in RUN. Handshake in the same cycle as reseed_req completes first; the pending out_reg word is discarded.
- reseed_req outside RUN ignored; seed_ready outside WAIT ignored.
- FAULT: seed_req=0, rnd_valid=0, fault=1 until rst.
- rnd_data must not change while rnd_valid=1 and rnd_ready=0.

## Timing
- Reset values: seed_req=0, rnd_valid=0, rnd_data=0, fault=0; state regs, counters zero. seed_req asserts in the first cycle after rst deasserts.
- seed_ready sampled high in WAIT at edge N → PRIME in cycle N+1 → rnd_valid=1 from cycle N+2.
- Throughput: one word per cycle while rnd_ready=1.
- Last handshake (or reseed_req) at edge N → rnd_valid=0 and seed_req=1 in cycle N+1.
- Reject at edge N → seed_req=1 in cycle N+1 (or fault=1 in N+1 if limit reached).
- rst assertion mid-operation: all outputs return to reset values immediately; any partial seed discarded.

## Configuration
- DRBG_SEED_REPEAT_CHECK_EN defined: a 256-bit register holds the last accepted seed (reset 0); a seed equal to it is also rejected and counted as a retry.
- Undefined: only the zero-seed check exists; no previous-seed register is built.

## Structure
- drbg_pkg: FSM state enum, rotation constants (7, 17, 45), multiplier constants (5, 9), default RESEED_INTERVAL.
- Sub-module xoshiro256ss_step: purely combinational; inputs s0..s3, outputs next s0..s3 and scrambled word. Top holds FSM, counters, registers.

## Test plan
- Seed s0=1,s1=2,s2=3,s3=4, rnd_ready=1 → first rnd_data=0x0000000000002D00, second=0x0000000000000000, rnd_valid high from 2 cycles after seed_ready.
- RESEED_INTERVAL=4, rnd_ready=1 → exactly 4 words, then rnd_valid=0 and one seed_req pulse next cycle; new seed yields fresh stream.
- rnd_ready held 0 for 5 cycles in RUN → rnd_data stable, counter unchanged, no state advance.
- Three zero seeds (MAX_SEED_RETRY=3) → seed_req pulses 3 times, fault=1 afterwards, rnd_valid stays 0; rst clears fault and seed_req re-pulses.
- reseed_req with simultaneous handshake → that word accepted, next cycle rnd_valid=0, seed_req=1.
- With DRBG_SEED_REPEAT_CHECK_EN: same nonzero seed delivered twice across a reseed → second counted as reject, seed_req re-pulses; without macro → accepted.
